// File: rtl/ysyx_23060111_pkg.sv
// Shared types and constants for the load/store unit.
package ysyx_23060111_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Flags direction conflicts, undefined funct3 codes and misaligned accesses.
  function automatic logic lsu_illegal(input logic       ren,
                                       input logic       wen,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (ren == wen) begin
      bad = 1'b1;
    end else if (ren && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)) begin
      bad = 1'b1;
    end else if (wen && (funct3 > F3_SW)) begin
      bad = 1'b1;
    end
    if (funct3[1:0] == 2'b01 && addr_lo[0]) bad = 1'b1;
    if (funct3[1:0] == 2'b10 && addr_lo != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_23060111_lsu_align.sv
// Byte-lane steering for stores and shift/extend for loads.
module ysyx_23060111_lsu_align
  import ysyx_23060111_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb_c,
  output logic [31:0] wdata_c,
  output logic [31:0] rdata_c
);

  logic [31:0] shifted;

  // Store strobes and lane-replicated write data.
  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = wdata;
    case (funct3)
      F3_SB: begin
        wstrb_c = 4'b0001 << addr_lo;
        wdata_c = {4{wdata[7:0]}};
      end
      F3_SH: begin
        wstrb_c = 4'b0011 << addr_lo;
        wdata_c = {2{wdata[15:0]}};
      end
      F3_SW: begin
        wstrb_c = 4'b1111;
        wdata_c = wdata;
      end
      default: begin
        wstrb_c = 4'b0000;
        wdata_c = wdata;
      end
    endcase
  end

  // Load data moved down to lane 0, then sign- or zero-extended.
  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    rdata_c = 32'd0;
    case (funct3)
      F3_LB:   rdata_c = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   rdata_c = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   rdata_c = rdata;
      F3_LBU:  rdata_c = {24'd0, shifted[7:0]};
      F3_LHU:  rdata_c = {16'd0, shifted[15:0]};
      default: rdata_c = 32'd0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060111_lsu_ctrl.sv
// Load/store controller: accepts one op, runs one bus access, returns the result.
module ysyx_23060111_lsu_ctrl
  import ysyx_23060111_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_ren,
  input  logic        in_wen,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic             ren_q, ren_d;

  logic             in_ready_d, out_valid_d, out_err_d;
  logic [31:0]      out_rdata_d;
  logic             mem_req_d, mem_we_d;
  logic [31:0]      mem_addr_d, mem_wdata_d;
  logic [3:0]       mem_wstrb_d;

  logic [2:0]       al_funct3;
  logic [1:0]       al_addr_lo;
  logic [3:0]       al_wstrb_c;
  logic [31:0]      al_wdata_c, al_rdata_c;

  // Aligner sees the incoming op while idle and the captured op afterwards.
  assign al_funct3  = (state_q == ST_IDLE) ? in_funct3    : funct3_q;
  assign al_addr_lo = (state_q == ST_IDLE) ? in_addr[1:0] : addr_lo_q;

  ysyx_23060111_lsu_align u_align (
    .funct3  (al_funct3),
    .addr_lo (al_addr_lo),
    .wdata   (in_wdata),
    .rdata   (mem_rdata),
    .wstrb_c (al_wstrb_c),
    .wdata_c (al_wdata_c),
    .rdata_c (al_rdata_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      funct3_q  <= 3'd0;
      addr_lo_q <= 2'd0;
      ren_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_rdata <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'b0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      ren_q     <= ren_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_err   <= out_err_d;
      out_rdata <= out_rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wstrb <= mem_wstrb_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    ren_d       = ren_q;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    out_err_d   = out_err;
    out_rdata_d = out_rdata;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wstrb_d = mem_wstrb;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          funct3_d   = in_funct3;
          addr_lo_d  = in_addr[1:0];
          ren_d      = in_ren;
          in_ready_d = 1'b0;
          if (lsu_illegal(in_ren, in_wen, in_funct3, in_addr[1:0])) begin
            state_d     = ST_RESP;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_rdata_d = 32'd0;
          end else begin
            state_d     = ST_BUS;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = in_wen;
            mem_addr_d  = {in_addr[31:2], 2'b00};
            mem_wdata_d = in_wen ? al_wdata_c : 32'd0;
            mem_wstrb_d = in_wen ? al_wstrb_c : 4'b0000;
          end
        end
      end

      ST_BUS: begin
        if (mem_ack) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          out_valid_d = 1'b1;
          out_err_d   = 1'b0;
          out_rdata_d = ren_q ? al_rdata_c : 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d     = ST_RESP;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_wstrb_d = 4'b0000;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_rdata_d = 32'd0;
          end
        end
      end

      ST_RESP: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          out_rdata_d = 32'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
